// File: rtl/free_list_pkg.sv
// Shared helpers for the free-list allocator: one-hot decode, popcount and the
// reset pattern that marks the RESET_BUSY reserved entries as busy.
package free_list_pkg;

    localparam int MAX_N = 64;
    typedef logic [MAX_N-1:0] vec_t;

    function automatic vec_t onehot(input int idx, input int n);
        vec_t v;
        v = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i == idx && i < n) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic int popcount(input vec_t v);
        int c;
        c = 0;
        for (int i = 0; i < MAX_N; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

    // Bit i is set for entries free out of reset: RESET_BUSY <= i < n.
    function automatic vec_t reset_mask(input int reset_busy, input int n);
        vec_t v;
        v = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i >= reset_busy && i < n) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/pri_enc_lsb.sv
// Lowest-set-bit priority encoder: multi-hot vector to binary index plus valid.
// Index is 0 when no bit is set.
module pri_enc_lsb #(
    parameter int N = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        idx   = '0;
        valid = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/free_list_alloc.sv
// Free-list allocator: registered free bit-vector handing out the lowest free entry.
// Optional sticky illegal-operation checker enabled by defining FREE_LIST_CHECK_EN.
module free_list_alloc
    import free_list_pkg::*;
#(
    parameter int N          = 8,
    parameter int RESET_BUSY = 0,
    localparam int IW = $clog2(N),
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          alloc_valid,
    output logic [IW-1:0] alloc_idx,
    input  logic          alloc_en,
    input  logic          free_en,
    input  logic [IW-1:0] free_idx,
    input  logic          flush,
    output logic [CW-1:0] free_count,
    output logic          err
);

    localparam logic [N-1:0] RESET_VAL = N'(reset_mask(RESET_BUSY, N));

    logic [N-1:0] free_q;
    logic [N-1:0] free_d;
    logic [N-1:0] alloc_mask;
    logic [N-1:0] ret_mask;
    logic         alloc_fire;
    logic         free_legal;

    pri_enc_lsb #(.N(N)) u_enc (
        .vec   (free_q),
        .idx   (alloc_idx),
        .valid (alloc_valid)
    );

    assign alloc_fire = alloc_en && alloc_valid;
    // Reserved entries never join the pool, so returning one is dropped.
    assign free_legal = free_en && RESET_VAL[free_idx];
    assign alloc_mask = alloc_fire ? N'(onehot(int'(alloc_idx), N)) : '0;
    assign ret_mask   = free_legal ? N'(onehot(int'(free_idx), N)) : '0;

    // Set is applied after clear so a same-index alloc/free leaves the bit free.
    always_comb begin
        free_d = (free_q & ~alloc_mask) | ret_mask;
        if (flush) free_d = RESET_VAL;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) free_q <= RESET_VAL;
        else     free_q <= free_d;
    end

    assign free_count = CW'(popcount(vec_t'(free_q)));

`ifdef FREE_LIST_CHECK_EN
    logic err_q;
    logic illegal;

    assign illegal = !flush &&
                     ((free_en && free_q[free_idx]) ||
                      (alloc_en && !alloc_valid) ||
                      (free_en && !RESET_VAL[free_idx]));

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_q | illegal;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
